// File: rtl/riscv_fetch.sv
// Instruction fetch front end: sequential PC generation, req/gnt imem interface, in-order prefetch FIFO.
// Optional macro FETCH_STALL_CNT_EN adds o_stall_cycles, a saturating count of cycles with no valid instruction.
module riscv_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_instr_valid,
   output logic [31:0] o_instr,
   output logic [31:0] o_instr_pc,
   input  logic        i_instr_ready
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [31:0] o_stall_cycles
`endif
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_W = FIFO_DEPTH[CNT_W:0];

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [31:0]        fetch_pc_q, fetch_pc_d;
   logic [31:0]        resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0]   outstanding_q, outstanding_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

   logic               req_fire;
   logic               rsp_live;
   logic               pop;
   logic               push;
   logic [CNT_W:0]     credit_used;
   logic [31:0]        redirect_pc_aligned;
   logic               unused_redirect_lsbs;

   logic [FIFO_DEPTH-1:0][31:0] entry_pc_vec;
   logic [FIFO_DEPTH-1:0][31:0] entry_instr_vec;

   assign redirect_pc_aligned  = {i_redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

   // Every in-flight request already owns a FIFO slot, so responses can never overflow.
   assign credit_used   = {1'b0, outstanding_q} + {1'b0, count_q};
   assign o_imem_req    = (state_q == S_RUN) && (credit_used < DEPTH_W);
   assign o_imem_addr   = fetch_pc_q;

   assign req_fire      = o_imem_req & i_imem_gnt;
   assign rsp_live      = i_imem_rvalid & (outstanding_q != '0);
   assign o_instr_valid = (count_q != '0);
   assign pop           = o_instr_valid & i_instr_ready;

   assign o_instr       = o_instr_valid ? entry_instr_vec[rd_ptr_q] : 32'h0;
   assign o_instr_pc    = o_instr_valid ? entry_pc_vec[rd_ptr_q]    : 32'h0;

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q;
      count_d       = count_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      push          = 1'b0;

      if (req_fire) begin
         fetch_pc_d    = fetch_pc_q + 32'd4;
         outstanding_d = outstanding_d + CNT_W'(1);
      end
      if (rsp_live) begin
         outstanding_d = outstanding_d - CNT_W'(1);
      end

      // A redirect voids any same-cycle push or pop; granted requests stay counted to be drained.
      if (i_redirect) begin
         fetch_pc_d = redirect_pc_aligned;
         resp_pc_d  = redirect_pc_aligned;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         state_d    = (outstanding_d != '0) ? S_DRAIN : S_RUN;
      end else begin
         case (state_q)
            S_BOOT: begin
               state_d = S_RUN;
            end
            S_RUN: begin
               push = rsp_live;
               if (push) begin
                  wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                  resp_pc_d = resp_pc_q + 32'd4;
               end
               if (pop) begin
                  rd_ptr_d = rd_ptr_q + PTR_W'(1);
               end
               case ({push, pop})
                  2'b10:   count_d = count_q + CNT_W'(1);
                  2'b01:   count_d = count_q - CNT_W'(1);
                  default: count_d = count_q;
               endcase
            end
            S_DRAIN: begin
               if (outstanding_d == '0) begin
                  state_d = S_RUN;
               end
            end
            default: begin
               state_d = S_BOOT;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= S_BOOT;
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
      end
   end

   // Storage needs no reset: outputs are gated by o_instr_valid.
   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
         logic [31:0] pc_q, pc_d;
         logic [31:0] instr_q, instr_d;

         always_comb begin
            pc_d    = pc_q;
            instr_d = instr_q;
            if (push && (wr_ptr_q == PTR_W'(gi))) begin
               pc_d    = resp_pc_q;
               instr_d = i_imem_rdata;
            end
         end

         always_ff @(posedge i_clk) begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
         end

         assign entry_pc_vec[gi]    = pc_q;
         assign entry_instr_vec[gi] = instr_q;
      end
   endgenerate

`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!o_instr_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         stall_cnt_q <= 32'h0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign o_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_fetch.sv
// Self-checking bench for riscv_fetch: latency-configurable imem responder plus decode scoreboard.
`timescale 1ns/1ps
module tb_riscv_fetch;
   localparam logic [31:0] RESET_PC = 32'h0000_0100;
   localparam int          DEPTH    = 2;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt = 1'b0;
   logic        i_imem_rvalid = 1'b0;
   logic [31:0] i_imem_rdata = 32'h0;
   logic        i_redirect = 1'b0;
   logic [31:0] i_redirect_pc = 32'h0;
   logic        o_instr_valid;
   logic [31:0] o_instr;
   logic [31:0] o_instr_pc;
   logic        i_instr_ready = 1'b0;
`ifdef FETCH_STALL_CNT_EN
   logic [31:0] o_stall_cycles;
   logic [31:0] tb_stall = 32'h0;
`endif

   riscv_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_gnt    (i_imem_gnt),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_instr_valid (o_instr_valid),
      .o_instr       (o_instr),
      .o_instr_pc    (o_instr_pc),
      .i_instr_ready (i_instr_ready)
`ifdef FETCH_STALL_CNT_EN
      ,
      .o_stall_cycles(o_stall_cycles)
`endif
   );

   initial forever #5 i_clk = ~i_clk;

   typedef struct { logic [31:0] addr; int due; } pend_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

   pend_t       pend_q[$];
   exp_t        exp_q[$];
   logic [31:0] pop_log[$];
   exp_t        exp_e;
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          lat = 2;
   bit          gnt_en = 1'b0;
   bit          gnt_rand = 1'b0;
   logic [31:0] exp_fetch = RESET_PC;
   bit          hold_prev = 1'b0;
   logic [31:0] hold_addr = 32'h0;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Instruction memory: grants on demand, answers in order after lat cycles.
   initial forever begin
      @(posedge i_clk);
      cyc++;
      #1;
      i_imem_gnt = gnt_en && (gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
         i_imem_rvalid = 1'b1;
         i_imem_rdata  = mem_fn(pend_q[0].addr);
         void'(pend_q.pop_front());
      end else begin
         i_imem_rvalid = 1'b0;
         i_imem_rdata  = 32'hDEAD_BEEF;
      end
   end

   // Monitor and scoreboard, sampled on the falling edge.
   initial forever begin
      @(negedge i_clk);
      if (i_rst) begin
         exp_q.delete();
         exp_fetch = RESET_PC;
         hold_prev = 1'b0;
`ifdef FETCH_STALL_CNT_EN
         tb_stall = 32'h0;
`endif
      end else begin
`ifdef FETCH_STALL_CNT_EN
         n_vec++;
         if (o_stall_cycles !== tb_stall) begin
            n_err++;
            $display("FAIL stall_cycles: got %0d want %0d", o_stall_cycles, tb_stall);
         end
         if (!o_instr_valid && tb_stall != 32'hFFFF_FFFF) tb_stall++;
`endif
         if (hold_prev) begin
            n_vec++;
            if (o_imem_req !== 1'b1 || o_imem_addr !== hold_addr) begin
               n_err++;
               $display("FAIL addr_hold: got req=%b addr=%h want req=1 addr=%h", o_imem_req, o_imem_addr, hold_addr);
            end
         end
         hold_prev = o_imem_req && !i_imem_gnt && !i_redirect;
         hold_addr = o_imem_addr;

         if (!i_redirect && o_instr_valid && i_instr_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_pop: got pc=%h instr=%h want no valid instruction", o_instr_pc, o_instr);
            end else begin
               exp_e = exp_q.pop_front();
               if (o_instr_pc !== exp_e.pc || o_instr !== exp_e.instr) begin
                  n_err++;
                  $display("FAIL decode_out: got pc=%h instr=%h want pc=%h instr=%h", o_instr_pc, o_instr, exp_e.pc, exp_e.instr);
               end
            end
            pop_log.push_back(o_instr_pc);
            $display("pop pc=%h instr=%h", o_instr_pc, o_instr);
         end

         if (o_imem_req && i_imem_gnt) begin
            pend_q.push_back('{o_imem_addr, cyc + lat});
            n_vec++;
            if (o_imem_addr !== exp_fetch) begin
               n_err++;
               $display("FAIL fetch_addr: got %h want %h", o_imem_addr, exp_fetch);
            end
            if (!i_redirect) exp_q.push_back('{exp_fetch, mem_fn(exp_fetch)});
            exp_fetch = exp_fetch + 32'd4;
         end

         if (i_redirect) begin
            exp_q.delete();
            exp_fetch = {i_redirect_pc[31:2], 2'b00};
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      i_rst = 1'b1; gnt_en = 1'b0; gnt_rand = 1'b0; lat = 2;
      i_instr_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
      repeat (2) @(posedge i_clk);
      #2;
      pend_q.delete();
      pop_log.delete();
      n_vec++; if (o_imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", o_imem_req); end
      n_vec++; if (o_imem_addr !== RESET_PC) begin n_err++; $display("FAIL reset_addr: got %h want %h", o_imem_addr, RESET_PC); end
      n_vec++; if (o_instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_instr_valid); end
      n_vec++; if (o_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", o_instr); end
      n_vec++; if (o_instr_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", o_instr_pc); end
      i_rst = 1'b0;
      $display("reset checked");
   endtask

   task automatic test_gnt_stall();
      for (int i = 0; i < 5; i++) begin
         @(posedge i_clk); #2;
         n_vec++;
         if (o_imem_req !== 1'b1 || o_imem_addr !== RESET_PC || o_instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL gnt_stall: got req=%b addr=%h valid=%b want req=1 addr=%h valid=0", o_imem_req, o_imem_addr, o_instr_valid, RESET_PC);
         end
         $display("stall cycle %0d req=%b addr=%h", i, o_imem_req, o_imem_addr);
      end
      gnt_en = 1'b1;
   endtask

   task automatic test_sequential();
      bit found = 1'b0;
      i_instr_ready = 1'b1;
      for (int i = 0; i < 20 && !found; i++) begin
         @(posedge i_clk); #2;
         if (i_imem_rvalid) found = 1'b1;
      end
      n_vec++;
      if (!found) begin n_err++; $display("FAIL first_rvalid: got none in 20 cycles want one"); end
      n_vec++; if (o_instr_valid !== 1'b0) begin n_err++; $display("FAIL empty_before_first: got valid=%b want 0", o_instr_valid); end
      @(posedge i_clk); #2;
      n_vec++;
      if (o_instr_valid !== 1'b1 || o_instr_pc !== RESET_PC || o_instr !== mem_fn(RESET_PC)) begin
         n_err++;
         $display("FAIL first_latency: got valid=%b pc=%h instr=%h want valid=1 pc=%h instr=%h", o_instr_valid, o_instr_pc, o_instr, RESET_PC, mem_fn(RESET_PC));
      end
      for (int i = 0; i < 50 && pop_log.size() < 3; i++) @(posedge i_clk);
      #2;
      n_vec++;
      if (pop_log.size() < 3) begin
         n_err++; $display("FAIL seq_timeout: got %0d pops want 3", pop_log.size());
      end else if (pop_log[0] !== 32'h100 || pop_log[1] !== 32'h104 || pop_log[2] !== 32'h108) begin
         n_err++; $display("FAIL seq_pcs: got %h %h %h want 100 104 108", pop_log[0], pop_log[1], pop_log[2]);
      end
   endtask

   task automatic test_backpressure();
      int n0;
      i_instr_ready = 1'b0;
      gnt_rand = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge i_clk); #2;
         n_vec++;
         if (o_imem_req !== (exp_q.size() < DEPTH)) begin
            n_err++;
            $display("FAIL credit: got req=%b want %b (in flight %0d)", o_imem_req, (exp_q.size() < DEPTH), exp_q.size());
         end
      end
      n_vec++; if (o_instr_valid !== 1'b1) begin n_err++; $display("FAIL fifo_full_valid: got %b want 1", o_instr_valid); end
      i_instr_ready = 1'b1;
      n0 = pop_log.size();
      for (int i = 0; i < 100 && pop_log.size() < n0 + 6; i++) @(posedge i_clk);
      #2;
      n_vec++; if (pop_log.size() < n0 + 6) begin n_err++; $display("FAIL bp_release: got %0d pops want 6", pop_log.size() - n0); end
      gnt_rand = 1'b0;
   endtask

   task automatic test_redirect_drain();
      bit found = 1'b0;
      bit saw_req = 1'b0;
      int drain = 0;
      int n0;
      lat = 4;
      i_instr_ready = 1'b1;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge i_clk); #2;
         if (pend_q.size() == 2 && !i_imem_rvalid) found = 1'b1;
      end
      n_vec++; if (!found) begin n_err++; $display("FAIL two_outstanding: got none want 2 in flight"); end
      i_redirect = 1'b1; i_redirect_pc = 32'h0000_0203;
      @(posedge i_clk); #2;
      i_redirect = 1'b0;
      n0 = pop_log.size();
      for (int i = 0; i < 30 && !saw_req; i++) begin
         if (o_imem_req) saw_req = 1'b1;
         else begin drain++; @(posedge i_clk); #2; end
      end
      n_vec++; if (!saw_req || drain < 1) begin n_err++; $display("FAIL drain_cycles: got %0d (req seen %b) want >=1 then req", drain, saw_req); end
      n_vec++; if (pend_q.size() != 0 || i_imem_rvalid) begin n_err++; $display("FAIL drain_complete: got %0d still pending want 0", pend_q.size()); end
      n_vec++; if (o_imem_addr !== 32'h200) begin n_err++; $display("FAIL redirect_addr: got %h want 00000200", o_imem_addr); end
      for (int i = 0; i < 40 && pop_log.size() <= n0; i++) @(posedge i_clk);
      #2;
      n_vec++;
      if (pop_log.size() <= n0) begin n_err++; $display("FAIL redirect_pop: got no pop want pc 00000200"); end
      else if (pop_log[n0] !== 32'h200) begin n_err++; $display("FAIL redirect_pop: got %h want 00000200", pop_log[n0]); end
   endtask

   task automatic test_same_cycle();
      bit found = 1'b0;
      int n0;
      lat = 1;
      for (int i = 0; i < 60 && !found; i++) begin
         @(posedge i_clk); #2;
         if (o_imem_req && i_imem_gnt && i_imem_rvalid) found = 1'b1;
      end
      n_vec++; if (!found) begin n_err++; $display("FAIL same_cycle_setup: got no req&gnt&rvalid cycle want one"); end
      i_redirect = 1'b1; i_redirect_pc = 32'h0000_0400;
      @(posedge i_clk); #2;
      i_redirect = 1'b0;
      n0 = pop_log.size();
      n_vec++; if (o_imem_req !== 1'b0 || o_instr_valid !== 1'b0) begin n_err++; $display("FAIL same_cycle_drain: got req=%b valid=%b want 0 0", o_imem_req, o_instr_valid); end
      for (int i = 0; i < 40 && pop_log.size() <= n0; i++) @(posedge i_clk);
      #2;
      n_vec++;
      if (pop_log.size() <= n0) begin n_err++; $display("FAIL same_cycle_pop: got no pop want pc 00000400"); end
      else if (pop_log[n0] !== 32'h400) begin n_err++; $display("FAIL same_cycle_pop: got %h want 00000400", pop_log[n0]); end
   endtask

   task automatic test_wrap();
      int n0;
      lat = 2;
      @(posedge i_clk); #2;
      i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFF8;
      @(posedge i_clk); #2;
      i_redirect = 1'b0;
      n0 = pop_log.size();
      for (int i = 0; i < 60 && pop_log.size() < n0 + 3; i++) @(posedge i_clk);
      #2;
      n_vec++;
      if (pop_log.size() < n0 + 3) begin
         n_err++; $display("FAIL wrap_timeout: got %0d pops want 3", pop_log.size() - n0);
      end else if (pop_log[n0] !== 32'hFFFF_FFF8 || pop_log[n0+1] !== 32'hFFFF_FFFC || pop_log[n0+2] !== 32'h0) begin
         n_err++; $display("FAIL wrap_pcs: got %h %h %h want fffffff8 fffffffc 00000000", pop_log[n0], pop_log[n0+1], pop_log[n0+2]);
      end
   endtask

   initial begin
      test_reset();
      test_gnt_stall();
      test_sequential();
      test_backpressure();
      test_redirect_drain();
      test_same_cycle();
      test_wrap();
      repeat (3) @(posedge i_clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
